// File: rtl/rotate_pkg.sv
// Shared types and width helpers for the rotate-amount sequencer and its button debouncers.
package rotate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    localparam int unsigned N_DEF         = 3;
    localparam int unsigned TICK_DIV_DEF  = 50_000_000;
    localparam int unsigned DB_CYCLES_DEF = 1_000_000;

    // Bits needed to hold 0..count-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-level filter for one raw push button; emits a single-cycle press strobe.
module button_debounce
    import rotate_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

    logic          sync0_q;
    logic          sync1_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    // Down-counter is reloaded on every matching cycle, so any gap restarts the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= btn_raw;
            sync1_q <= sync0_q;
            pulse_q <= 1'b0;
            if (sync1_q == level_q) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync1_q;
                pulse_q <= sync1_q;
                cnt_q   <= RELOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level       = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/rotate_amt_sequencer.sv
// Loads the rotator operand from switches and animates the rotate amount at a programmable tick rate.
//   state | meaning
//   IDLE  | nothing loaded yet; RUN presses ignored
//   PAUSE | operand loaded, amt frozen, prescaler held
//   RUN   | prescaler counting, amt steps on each terminal count
module rotate_amt_sequencer
    import rotate_pkg::*;
#(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2**N-1:0]   sw_data,
    input  logic              btn_load,
    input  logic              btn_run,
    input  logic              dir,
    output logic [2**N-1:0]   a,
    output logic [N-1:0]      amt,
    output logic              running,
    output logic              step_pulse
);

    localparam int unsigned PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic load_p;
    logic run_p;
    logic load_level_unused;
    logic run_level_unused;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_load),
        .level       (load_level_unused),
        .press_pulse (load_p)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_run),
        .level       (run_level_unused),
        .press_pulse (run_p)
    );

    seq_state_t        state_q;
    logic [PW-1:0]     presc_q;
    logic [2**N-1:0]   a_q;
    logic [N-1:0]      amt_q;
    logic [N-1:0]      amt_step_d;
    logic              running_q;
    logic              step_q;

    assign amt_step_d = dir ? (amt_q - 1'b1) : (amt_q + 1'b1);

    // Load is checked before run everywhere, so a coincident run press is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            a_q       <= '0;
            amt_q     <= '0;
            running_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_p) begin
                        a_q     <= sw_data;
                        amt_q   <= '0;
                        presc_q <= '0;
                        state_q <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (load_p) begin
                        a_q     <= sw_data;
                        amt_q   <= '0;
                        presc_q <= '0;
                    end else if (run_p) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (load_p) begin
                        a_q       <= sw_data;
                        amt_q     <= '0;
                        presc_q   <= '0;
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (run_p) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_q <= '0;
                        amt_q   <= amt_step_d;
                        step_q  <= 1'b1;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign a          = a_q;
    assign amt        = amt_q;
    assign running    = running_q;
    assign step_pulse = step_q;

endmodule

// File: tb/tb_rotate_amt_sequencer.sv
// Scenario bench for rotate_amt_sequencer with small tick and debounce settings.
module tb_rotate_amt_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_data;
    logic       btn_load;
    logic       btn_run;
    logic       dir;
    logic [7:0] a;
    logic [2:0] amt;
    logic       running;
    logic       step_pulse;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    rotate_amt_sequencer #(.N(3), .TICK_DIV(TD), .DB_CYCLES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_data    (sw_data),
        .btn_load   (btn_load),
        .btn_run    (btn_run),
        .dir        (dir),
        .a          (a),
        .amt        (amt),
        .running    (running),
        .step_pulse (step_pulse)
    );

    function automatic logic [7:0] ror8(input logic [7:0] v, input logic [2:0] s);
        return (v >> s) | (v << (8 - s));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic ld, input logic rn, input int hold);
        btn_load = ld;
        btn_run  = rn;
        cyc(hold);
        btn_load = 1'b0;
        btn_run  = 1'b0;
    endtask

    // sel 0 watches running, sel 1 watches step_pulse; n is negedges waited
    task automatic wait_sig(input int sel, input logic val, input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (((sel == 0) ? running : step_pulse) === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; sw_data = 8'h00; btn_load = 1'b0; btn_run = 1'b0; dir = 1'b0;
        cyc(3);
        total++;
        if ({a, amt, running, step_pulse} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got a=%h amt=%0d run=%b step=%b want all 0", a, amt, running, step_pulse);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_run_in_idle;
        btn_run = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) btn_run = 1'b0;
            @(negedge clk);
            total++;
            if ({a, amt, running, step_pulse} !== 13'h0) begin
                bad++;
                $display("FAIL idle_run_ignored cyc %0d: got a=%h amt=%0d run=%b step=%b want all 0", i, a, amt, running, step_pulse);
            end
        end
    endtask

    task automatic test_load;
        sw_data = 8'hB4;
        press(1'b1, 1'b0, 8);
        cyc(4);
        total++;
        if (a !== 8'hB4 || amt !== 3'd0 || running !== 1'b0) begin
            bad++;
            $display("FAIL load: got a=%h amt=%0d run=%b want a=b4 amt=0 run=0", a, amt, running);
        end
        sw_data = 8'hFF;
        cyc(12);
        total++;
        if (a !== 8'hB4) begin
            bad++;
            $display("FAIL sw_ignored: got a=%h want b4", a);
        end
    endtask

    task automatic test_run_steps;
        int n;
        bit ok;
        logic [2:0] e;
        dir = 1'b0;
        for (int k = 1; k <= 8; k++) exp_q.push_back(3'(k));
        press(1'b0, 1'b1, 5);
        wait_sig(0, 1'b1, 10, n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL run_enter: running stayed %b want 1", running);
        end
        for (int k = 0; k < 8; k++) begin
            wait_sig(1, 1'b1, TD + 2, n, ok);
            total++;
            if (!ok || n !== TD) begin
                bad++;
                $display("FAIL step_period %0d: got %0d cycles (seen=%b) want %0d", k, n, ok, TD);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
            total++;
            if (amt !== e) begin
                bad++;
                $display("FAIL step_amt %0d: got %0d want %0d", k, amt, e);
            end
            if (k == 0) begin
                total++;
                if (ror8(a, amt) !== 8'h5A) begin
                    bad++;
                    $display("FAIL rotated_first: got %h want 5a", ror8(a, amt));
                end
            end
        end
        sw_data = 8'hB4;
        press(1'b1, 1'b0, 5);
        wait_sig(0, 1'b0, 10, n, ok);
        total++;
        if (!ok || a !== 8'hB4 || amt !== 3'd0) begin
            bad++;
            $display("FAIL reload_in_run: got run=%b a=%h amt=%0d want run=0 a=b4 amt=0", running, a, amt);
        end
    endtask

    task automatic test_bounce;
        int changed;
        sw_data  = 8'hFF;
        changed  = 0;
        btn_load = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            btn_load = (i < 11) ? ~btn_load : 1'b0;
            if (a !== 8'hB4) changed++;
        end
        total++;
        if (changed != 0) begin
            bad++;
            $display("FAIL bounce_toggle: got %0d cycles with a!=b4 want 0", changed);
        end
        changed  = 0;
        btn_load = 1'b1;
        cyc(2);
        btn_load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a !== 8'hB4) changed++;
        end
        total++;
        if (changed != 0) begin
            bad++;
            $display("FAIL bounce_short: got %0d cycles with a!=b4 want 0", changed);
        end
    endtask

    task automatic test_dir_pause_resume;
        int n;
        int moved;
        bit ok;
        logic [2:0] e;
        dir = 1'b1;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd6);
        press(1'b0, 1'b1, 5);
        wait_sig(0, 1'b1, 10, n, ok);
        wait_sig(1, 1'b1, TD + 2, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
        total++;
        if (!ok || n !== TD || amt !== e) begin
            bad++;
            $display("FAIL dec_step1: got amt=%0d after %0d cycles want %0d after %0d", amt, n, e, TD);
        end
        cyc(1);
        btn_run = 1'b1;
        wait_sig(1, 1'b1, 6, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
        total++;
        if (!ok || n !== 3 || amt !== e) begin
            bad++;
            $display("FAIL dec_step2: got amt=%0d after %0d cycles want %0d after 3", amt, n, e);
        end
        wait_sig(0, 1'b0, 6, n, ok);
        btn_run = 1'b0;
        total++;
        if (!ok || n !== 3 || amt !== 3'd6) begin
            bad++;
            $display("FAIL pause_point: got run=%b amt=%0d after %0d cycles want run=0 amt=6 after 3", running, amt, n);
        end
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_pulse !== 1'b0 || amt !== 3'd6 || running !== 1'b0) moved++;
        end
        total++;
        if (moved != 0) begin
            bad++;
            $display("FAIL pause_hold: got %0d active cycles want 0", moved);
        end
        exp_q.push_back(3'd5);
        press(1'b0, 1'b1, 5);
        wait_sig(0, 1'b1, 10, n, ok);
        wait_sig(1, 1'b1, TD + 2, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
        total++;
        if (!ok || n !== 2 || amt !== e) begin
            bad++;
            $display("FAIL resume_partial: got amt=%0d after %0d cycles want %0d after 2", amt, n, e);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit ok;
        press(1'b1, 1'b1, 5);
        wait_sig(0, 1'b0, 10, n, ok);
        total++;
        if (!ok || a !== 8'hFF || amt !== 3'd0) begin
            bad++;
            $display("FAIL load_wins: got run=%b a=%h amt=%0d want run=0 a=ff amt=0", running, a, amt);
        end
        cyc(20);
        total++;
        if (running !== 1'b0 || amt !== 3'd0) begin
            bad++;
            $display("FAIL run_dropped: got run=%b amt=%0d want run=0 amt=0", running, amt);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        bit ok;
        press(1'b0, 1'b1, 5);
        wait_sig(0, 1'b1, 10, n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rerun_enter: running stayed %b want 1", running);
        end
        cyc(3);
        btn_load = 1'b1;
        cyc(3);
        reset    = 1'b1;
        btn_load = 1'b0;
        cyc(1);
        total++;
        if ({a, amt, running, step_pulse} !== 13'h0) begin
            bad++;
            $display("FAIL reset_mid_run: got a=%h amt=%0d run=%b step=%b want all 0", a, amt, running, step_pulse);
        end
        reset = 1'b0;
        cyc(15);
        total++;
        if (a !== 8'h00 || running !== 1'b0) begin
            bad++;
            $display("FAIL inflight_discard: got a=%h run=%b want a=00 run=0", a, running);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_run_in_idle;
        test_load;
        test_run_steps;
        test_bounce;
        test_dir_pause_resume;
        test_back_to_back;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/rotate_amt_sequencer.md
Name: rotate_amt_sequencer

Overview:
Upstream control stage for the parameterised right rotator.
- Captures an operand from board switches on a debounced LOAD press.
- Drives the rotator's operand (a) and shift amount (amt).
- When running, steps amt once per programmable tick so the rotated pattern animates on the LEDs.
- Run/pause via a debounced RUN button; direction input selects amt increment or decrement.

Parameters:
N, 3, rotator select width; data width is 2**N.
TICK_DIV, 50_000_000, clk cycles per amt step; legal range is 2 or more.
DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level; legal range is 1 or more.

Ports:
clk  input  1  system clock; sole clock.
reset  input  1  synchronous, active-high reset.
sw_data  input  2**N  switch operand, asynchronous to clk.
btn_load  input  1  raw LOAD button, asynchronous and bouncy.
btn_run  input  1  raw RUN/PAUSE button, asynchronous and bouncy.
dir  input  1  0 increments amt per step, 1 decrements it (decrement emulates left rotation).
a  output  2**N  registered operand to the rotator.
amt  output  N  registered rotate amount to the rotator.
running  output  1  high while in RUN.
step_pulse  output  1  one-cycle strobe on the cycle amt changes due to a tick.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values:
  - State IDLE; a=0, amt=0, running=0, step_pulse=0, prescaler=0.
  - Debouncers: synchronisers, counters and stable levels all 0.
- Reset mid-operation: returns to IDLE on that edge; any in-flight button pulse is discarded.
- Button path (per button, in button_debounce):
  - 2-FF synchroniser.
  - Stable level updates once the synchronised input differs from it for DB_CYCLES consecutive cycles. Any mismatch gap restarts the count.
  - Press pulse is high for exactly one cycle, on the cycle the stable level goes 0->1.
  - Release produces no pulse.
- FSM states IDLE, PAUSE, RUN. The FSM acts on the edge following the press pulse.
  - IDLE: load_p -> a<=sw_data, amt<=0, prescaler<=0, go PAUSE. run_p is ignored.
  - PAUSE: load_p -> reload as above, stay PAUSE. run_p -> RUN.
  - RUN: load_p -> reload, go PAUSE. run_p -> PAUSE.
  - Simultaneous load_p and run_p: load wins, run_p is dropped.
- Prescaler (width $clog2(TICK_DIV)):
  - Counts only in RUN.
  - At TICK_DIV-1 it wraps to 0, amt steps, and step_pulse=1 for that cycle.
  - Holds its value in PAUSE, so resume finishes the partial period.
- amt arithmetic is modulo 2**N:
  - dir=0: 2**N-1 -> 0.
  - dir=1: 0 -> 2**N-1.
  - dir is sampled at each step edge; a change mid-period affects only the next step.
- a changes only on load; sw_data changes are otherwise ignored.
- running = (state==RUN), registered.

Decomposition:
- Package rotate_pkg:
  - typedef enum logic [1:0] {IDLE, PAUSE, RUN} seq_state_t.
  - Width helper localparams: data width 2**N, prescaler width, debounce counter width.
- Sub-module button_debounce:
  - Parameter DB_CYCLES.
  - Ports: clk, reset, btn_raw, level, press_pulse.
  - Instantiated twice, once per button.
- Sequencer FSM and prescaler stay in the top module.

Test Plan (N=3, TICK_DIV=4, DB_CYCLES=3 unless stated):
1. Reset, then a clean 10-cycle btn_run press in IDLE -> a=8'h00, amt=0, running=0, step_pulse=0 throughout.
2. sw_data=8'hB4, clean btn_load press -> exactly one load; a=8'hB4, amt=0, running=0. Changing sw_data to 8'hFF afterwards leaves a=8'hB4.
3. btn_run press with dir=0 -> running=1; step_pulse every 4 cycles; amt goes 1..7 then 0. Rotator output after first step is 8'h5A.
4. Bounce: btn_load toggling every cycle for 12 cycles, then low -> no load pulse, a unchanged. Toggling held high for 2 cycles then low -> still no pulse.
5. From amt=0 with dir=1 -> amt goes 7, 6. Pause after 2 prescaler cycles, wait 20 cycles, resume -> next step_pulse exactly 2 cycles after RUN re-entry.
6. In RUN, btn_load and btn_run pulses on the same cycle -> reload, amt=0, state PAUSE, running=0. Then assert reset mid-RUN -> IDLE with all outputs 0 on the next edge.
